// File: rtl/imem_boot_responder_pkg.sv
// Shared definitions for the instruction-memory boot responder.
//   NOP_INSTR    : canonical RISC-V NOP (addi x0,x0,0), also used by the fetch stage
//   imem_state_e : responder states HOLD (core held in reset), LOAD (image
//                  streaming in), RUN (core released, fetches served)
package imem_boot_responder_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IMEM_HOLD = 2'd0,
    IMEM_LOAD = 2'd1,
    IMEM_RUN  = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_boot_responder_if.sv
// Fetch bus plus byte-stream load port of the instruction-memory responder.
//   instruction_addr_i  : fetch byte address (bits [1:0] ignored)
//   instruction_rdata_o : fetch data, one cycle after the address
//   load_start_i/len_i  : start a program load of len words
//   load_byte_i/valid_i/ready_o : byte stream, accepted on valid & ready
//   load_done_o         : one-cycle pulse when the image is complete
//   core_rst_n_o        : active-low reset to the core
// slave  : the responder side
// master : the side driving fetches and the load stream
interface imem_boot_responder_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 12
) ();

  logic [MEM_ADDR_WIDTH-1:0] instruction_addr_i;
  logic [DATA_WIDTH-1:0]     instruction_rdata_o;
  logic                      load_start_i;
  logic [MEM_ADDR_WIDTH-2:0] load_len_i;
  logic [7:0]                load_byte_i;
  logic                      load_valid_i;
  logic                      load_ready_o;
  logic                      load_done_o;
  logic                      core_rst_n_o;

  modport slave (
    input  instruction_addr_i, load_start_i, load_len_i, load_byte_i, load_valid_i,
    output instruction_rdata_o, load_ready_o, load_done_o, core_rst_n_o
  );

  modport master (
    output instruction_addr_i, load_start_i, load_len_i, load_byte_i, load_valid_i,
    input  instruction_rdata_o, load_ready_o, load_done_o, core_rst_n_o
  );

endinterface

// File: rtl/imem_boot_responder_ram.sv
// imem_ram_1r1w: plain word-wide memory array, one write port and one read port.
//   clk   : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   raddr : read address, rdata registered (one-cycle latency)
// Contents are never cleared; unwritten words read as X in simulation.
module imem_ram_1r1w #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_boot_responder.sv
// Instruction-memory responder with boot loader.
// After reset the core is held in reset while a little-endian byte stream is
// packed into 32-bit words and written from word 0. When the requested number
// of words is in memory the core is released and fetches are served with one
// cycle of latency. Outside RUN every fetch returns NOP.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch and load port (slave side of imem_boot_responder_if)
// Only DATA_WIDTH = 32 is supported.
module imem_boot_responder
  import imem_boot_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_boot_responder_if.slave bus
);

  localparam int WORD_AW = MEM_ADDR_WIDTH - 2;
  localparam int LEN_W   = MEM_ADDR_WIDTH - 1;
  localparam int DEPTH   = 1 << WORD_AW;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

  // A length beyond the array is trimmed so the write pointer never wraps.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l > LEN_MAX) begin
      return LEN_MAX;
    end
    return l;
  endfunction

  imem_state_e           state_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      wptr_q;
  logic [LEN_W-1:0]      wptr_inc;
  logic [LEN_W-1:0]      start_len;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           asm_p0;
  logic                  load_done_q;
  logic                  core_rst_n_q;
  logic                  run_p1;
  logic                  accept;
  logic                  word_we;
  logic [DATA_WIDTH-1:0] word_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata_p1;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.instruction_addr_i[1:0];

  assign accept     = (state_q == IMEM_LOAD) && bus.load_valid_i;
  // The fourth byte goes straight into the write data, so the word is
  // written on the same edge that accepts it.
  assign word_we    = accept && (byte_cnt_q == 2'd3);
  assign word_wdata = {bus.load_byte_i, asm_p0};
  assign wptr_inc   = wptr_q + LEN_W'(1);
  assign start_len  = clamp_len(bus.load_len_i);

  // Load stage p0: byte lanes 0..2 of the word being assembled (data only).
  always_ff @(posedge clk) begin
    if (accept && (byte_cnt_q != 2'd3)) begin
      asm_p0[{byte_cnt_q, 3'b000} +: 8] <= bus.load_byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IMEM_HOLD;
      len_q        <= '0;
      wptr_q       <= '0;
      byte_cnt_q   <= '0;
      load_done_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
      run_p1       <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      // Selects RAM data for the fetch answered next cycle.
      run_p1      <= (state_q == IMEM_RUN);
      case (state_q)
        IMEM_HOLD, IMEM_RUN: begin
          if (bus.load_start_i) begin
            len_q      <= start_len;
            wptr_q     <= '0;
            byte_cnt_q <= '0;
            if (start_len == '0) begin
              state_q      <= IMEM_RUN;
              load_done_q  <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else begin
              state_q      <= IMEM_LOAD;
              core_rst_n_q <= 1'b0;
            end
          end
        end
        IMEM_LOAD: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (word_we) begin
              wptr_q <= wptr_inc;
              if (wptr_inc == len_q) begin
                state_q      <= IMEM_RUN;
                load_done_q  <= 1'b1;
                core_rst_n_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q      <= IMEM_HOLD;
          core_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  imem_ram_1r1w #(
    .ADDR_W (WORD_AW),
    .DATA_W (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (word_we),
    .waddr (wptr_q[WORD_AW-1:0]),
    .wdata (word_wdata),
    .raddr (bus.instruction_addr_i[MEM_ADDR_WIDTH-1:2]),
    .rdata (ram_rdata_p1)
  );

  // Fetch stage p1: registered RAM word or NOP, chosen by the registered select.
  assign bus.instruction_rdata_o = run_p1 ? ram_rdata_p1 : DATA_WIDTH'(NOP_INSTR);
  assign bus.load_ready_o        = (state_q == IMEM_LOAD);
  assign bus.load_done_o         = load_done_q;
  assign bus.core_rst_n_o        = core_rst_n_q;

endmodule

// File: tb/tb_imem_boot_responder.sv
// Bench for imem_boot_responder: table of load vectors with fixed expected
// words, hand sequences for reset/length corner cases, and a randomized phase.
// A behavioural model (byte counter, word array) checks every cycle.
module tb_imem_boot_responder;

  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst_n;

  imem_boot_responder_if #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(12)) bus ();

  imem_boot_responder #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Behavioural model: mode 0 = held, 1 = loading, 2 = running.
  logic [31:0] mdl_mem   [DEPTH];
  bit          mdl_known [DEPTH];
  logic [7:0]  pend [4];
  int          mode;
  int          mdl_total;
  int          mdl_cnt;
  bit          exp_done;

  typedef struct {
    int          len;
    logic [7:0]  b [8];
    int          vmode;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t tbl [4];
  logic [7:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clampw(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  function automatic logic [7:0] byte_at(input int k);
    return 8'((k * 37 + (k >> 5)) & 255);
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic step();
    bit pre_run;
    int pre_w;
    bit s;
    bit v;
    int l;
    logic [7:0] b;
    pre_run = (mode == 2);
    pre_w   = int'(bus.instruction_addr_i[11:2]);
    s       = bus.load_start_i;
    v       = bus.load_valid_i;
    l       = int'(bus.load_len_i);
    b       = bus.load_byte_i;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    if (mode != 1 && s) begin
      mdl_total = clampw(l) * 4;
      mdl_cnt   = 0;
      if (mdl_total == 0) begin
        mode     = 2;
        exp_done = 1'b1;
      end else begin
        mode = 1;
      end
    end else if (mode == 1 && v) begin
      pend[mdl_cnt % 4] = b;
      if (mdl_cnt % 4 == 3) begin
        mdl_mem[mdl_cnt / 4]   = {pend[3], pend[2], pend[1], pend[0]};
        mdl_known[mdl_cnt / 4] = 1'b1;
      end
      mdl_cnt++;
      if (mdl_cnt == mdl_total) begin
        mode     = 2;
        exp_done = 1'b1;
      end
    end
    chk("load_done", 32'(bus.load_done_o), 32'(exp_done));
    chk("core_rst_n", 32'(bus.core_rst_n_o), 32'(mode == 2));
    chk("load_ready", 32'(bus.load_ready_o), 32'(mode == 1));
    if (!pre_run) begin
      chk("rdata_nop", bus.instruction_rdata_o, NOP);
    end else if (mdl_known[pre_w]) begin
      chk("rdata_mem", bus.instruction_rdata_o, mdl_mem[pre_w]);
    end
  endtask

  task automatic apply_reset();
    bus.load_start_i = 1'b0;
    bus.load_valid_i = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_rdata", bus.instruction_rdata_o, NOP);
    chk("rst_ready", 32'(bus.load_ready_o), 32'd0);
    chk("rst_done", 32'(bus.load_done_o), 32'd0);
    chk("rst_core", 32'(bus.core_rst_n_o), 32'd0);
    mode     = 0;
    exp_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // vmode: 0 back-to-back, 1 valid every other cycle, 2 random valid with
  // stray start pulses that a loading responder must ignore.
  task automatic drive_load(input int ln, input logic [7:0] bq[$], input int vmode,
                            input int max_bytes);
    int k;
    int c;
    bit v;
    k = 0;
    c = 0;
    bus.load_len_i   = 11'(ln);
    bus.load_start_i = 1'b1;
    step();
    bus.load_start_i = 1'b0;
    while (k < max_bytes && c < 20000) begin
      if (vmode == 0)      v = 1'b1;
      else if (vmode == 1) v = (c % 2 == 0);
      else                 v = 1'($urandom_range(0, 1));
      bus.load_valid_i       = v;
      bus.load_byte_i        = (k < bq.size()) ? bq[k] : 8'h00;
      bus.instruction_addr_i = 12'($urandom_range(0, 4095));
      if (vmode == 2) begin
        bus.load_start_i = ($urandom_range(0, 7) == 0);
        bus.load_len_i   = 11'($urandom_range(0, 2047));
      end
      step();
      if (v) k++;
      c++;
    end
    if (k < max_bytes) begin
      n_cmp++;
      n_fail++;
      $display("FAIL load_budget: sent %0d bytes, required %0d", k, max_bytes);
    end
    bus.load_valid_i       = 1'b0;
    bus.load_start_i       = 1'b0;
    bus.instruction_addr_i = '0;
  endtask

  task automatic fetch(input string nm, input logic [11:0] a, input logic [31:0] exp);
    bus.instruction_addr_i = a;
    step();
    chk(nm, bus.instruction_rdata_o, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    n_cmp = 0;
    n_fail = 0;
    mode = 0;
    exp_done = 1'b0;
    bus.instruction_addr_i = '0;
    bus.load_start_i = 1'b0;
    bus.load_len_i = '0;
    bus.load_byte_i = '0;
    bus.load_valid_i = 1'b0;

    tbl[0].len = 2; tbl[0].vmode = 0;
    tbl[0].b = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    tbl[0].w0 = 32'h00100513; tbl[0].w1 = 32'h00200593;
    tbl[1].len = 2; tbl[1].vmode = 1;
    tbl[1].b = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    tbl[1].w0 = 32'h00100513; tbl[1].w1 = 32'h00200593;
    tbl[2].len = 1; tbl[2].vmode = 0;
    tbl[2].b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].w0 = 32'h12345678; tbl[2].w1 = 32'h00200593;
    tbl[3].len = 2; tbl[3].vmode = 2;
    tbl[3].b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02, 8'h03, 8'h04};
    tbl[3].w0 = 32'hDEADBEEF; tbl[3].w1 = 32'h04030201;

    // Idle after reset: core held, no load port, NOP on the fetch bus.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      bus.instruction_addr_i = 12'($urandom_range(0, 4095));
      step();
      chk("idle_rdata", bus.instruction_rdata_o, NOP);
      chk("idle_core", 32'(bus.core_rst_n_o), 32'd0);
    end

    // Table of loads with fixed expected words.
    for (int t = 0; t < 4; t++) begin
      apply_reset();
      q.delete();
      for (int j = 0; j < tbl[t].len * 4; j++) q.push_back(tbl[t].b[j]);
      drive_load(tbl[t].len, q, tbl[t].vmode, tbl[t].len * 4);
      chk("tbl_done_pulse", 32'(bus.load_done_o), 32'd1);
      chk("tbl_core_up", 32'(bus.core_rst_n_o), 32'd1);
      fetch("tbl_w0", 12'h000, tbl[t].w0);
      fetch("tbl_w1", 12'h004, tbl[t].w1);
      step();
      chk("tbl_done_once", 32'(bus.load_done_o), 32'd0);
    end

    // Zero-length load from HOLD: straight to RUN, nothing written.
    apply_reset();
    bus.load_len_i = '0;
    bus.load_start_i = 1'b1;
    step();
    bus.load_start_i = 1'b0;
    chk("len0_done", 32'(bus.load_done_o), 32'd1);
    chk("len0_core", 32'(bus.core_rst_n_o), 32'd1);
    fetch("len0_w0", 12'h000, 32'hDEADBEEF);
    fetch("len0_w1", 12'h005, 32'h04030201);

    // Reload from RUN with one word.
    bus.load_len_i = 11'd1;
    bus.load_start_i = 1'b1;
    step();
    bus.load_start_i = 1'b0;
    chk("reload_core_low", 32'(bus.core_rst_n_o), 32'd0);
    chk("reload_ready", 32'(bus.load_ready_o), 32'd1);
    q = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int j = 0; j < 4; j++) begin
      bus.load_valid_i = 1'b1;
      bus.load_byte_i = q[j];
      step();
      chk("reload_rdata_nop", bus.instruction_rdata_o, NOP);
    end
    bus.load_valid_i = 1'b0;
    chk("reload_done", 32'(bus.load_done_o), 32'd1);
    fetch("reload_w0", 12'h000, 32'hAABBCCDD);
    fetch("reload_w1", 12'h004, 32'h04030201);

    // Reset after 5 bytes of a 2-word load: word 0 kept, partial word dropped.
    apply_reset();
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    drive_load(2, q, 0, 5);
    apply_reset();
    pend[0] = 8'h00;
    bus.load_len_i = '0;
    bus.load_start_i = 1'b1;
    step();
    bus.load_start_i = 1'b0;
    fetch("abort_w0", 12'h000, 32'h44332211);
    fetch("abort_w1", 12'h004, 32'h04030201);

    // Randomized phase: fetches in RUN mixed with short reloads.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        int ln;
        ln = $urandom_range(1, 4);
        q.delete();
        for (int j = 0; j < ln * 4; j++) q.push_back(8'($urandom));
        drive_load(ln, q, 2, ln * 4);
      end else begin
        bus.instruction_addr_i = 12'($urandom_range(0, 31));
        step();
      end
    end

    // Oversized length: clamped to the full array.
    apply_reset();
    q.delete();
    for (int j = 0; j < 4096; j++) q.push_back(byte_at(j));
    drive_load(2047, q, 0, 4096);
    chk("clamp_done", 32'(bus.load_done_o), 32'd1);
    fetch("clamp_first", 12'h000, {byte_at(3), byte_at(2), byte_at(1), byte_at(0)});
    fetch("clamp_last", 12'hFFC, {byte_at(4095), byte_at(4094), byte_at(4093), byte_at(4092)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_responder.md
# imem_boot_responder

Instruction-memory responder for the fetch stage: it answers fetch addresses with a word one clock later (registered read data) and owns the program image. After reset it holds the core in reset and accepts a little-endian byte stream over a valid/ready load port. It packs the bytes into 32-bit words and writes them sequentially from word 0. Once the programmed length is written it releases the core, and from then on it serves fetches.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; only 32 is supported.
- MEM_ADDR_WIDTH, 12, byte-address width; depth = 2^(MEM_ADDR_WIDTH-2) words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- instruction_addr_i  in  MEM_ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- instruction_rdata_o  out  DATA_WIDTH  registered fetch data.
- load_start_i  in  1  begin a load; sampled in HOLD or RUN.
- load_len_i  in  MEM_ADDR_WIDTH-1  number of words to load; captured with load_start_i.
- load_byte_i  in  8  load data byte.
- load_valid_i  in  1  load byte valid.
- load_ready_o  out  1  load byte accepted when valid&ready.
- load_done_o  out  1  one-cycle pulse on LOAD->RUN.
- core_rst_n_o  out  1  registered active-low reset to the core.

## Operation
- Three states: HOLD (reset state), LOAD, RUN.
- HOLD:
  - core_rst_n_o=0, load_ready_o=0.
  - load_start_i=1 captures the length and clears the write pointer and byte counter.
  - If the captured length is 0, go to RUN; otherwise go to LOAD.
- LOAD:
  - load_ready_o=1.
  - Each accepted byte is placed in lane byte_cnt (byte 0 -> bits [7:0]), and byte_cnt increments mod 4.
  - On the 4th byte, write the assembled word to mem[wptr] on the same edge, then wptr++.
  - When wptr reaches len (after that write), go to RUN.
  - load_start_i is ignored in LOAD.
- RUN:
  - core_rst_n_o=1, load_ready_o=0.
  - load_start_i=1 re-enters the load sequence exactly as from HOLD; core_rst_n_o drops to 0 the next cycle.
- Length clamp: a load_len_i greater than depth is clamped to depth. wptr therefore never wraps, and no write goes past the last word.
- Fetch path:
  - Every cycle, rdata_q <= RUN ? mem[instruction_addr_i[MEM_ADDR_WIDTH-1:2]] : NOP (0x00000013).
  - No read enable and no stall input: the fetch stage holds its own copy when stalled.
- Memory contents are not cleared by reset; unloaded words read as X in simulation.
- A partial word (fewer than 4 bytes) is never written. A new load_start_i from RUN discards it, because byte_cnt clears on start.

## Timing
- Reset values:
  - instruction_rdata_o = 0x00000013.
  - load_ready_o = 0, load_done_o = 0, core_rst_n_o = 0.
  - State = HOLD; wptr, byte_cnt and len = 0.
- Read latency is 1 cycle: address presented in cycle N gives data valid in cycle N+1. This holds in every cycle of RUN, including the first.
- Write-to-read: a word written at edge E is returned for a fetch of that address presented in cycle E+1 or later.
- Same-address read and write in one cycle cannot occur, because fetches only return memory data in RUN and writes only happen in LOAD.
- LOAD->RUN transition:
  - The state changes on the edge after the final byte.
  - load_done_o and core_rst_n_o rise in the first RUN cycle, registered from the state transition.
  - The first fetch therefore sees loaded data.
- Length-0 load from HOLD: RUN is entered one cycle after load_start_i, and load_done_o pulses in that cycle.
- load_ready_o is a pure decode of state (combinational, no dependence on load_valid_i).
- Asynchronous reset at any point returns everything to reset values. An in-progress load is aborted, and words already written remain in memory.

## Structure
- Add to defines.vh: the NOP constant `NOP_INSTR (32'h00000013) and the state encodings IMEM_HOLD, IMEM_LOAD and IMEM_RUN.
- The NOP constant is shared with the fetch stage.
- Sub-module imem_ram_1r1w holds only the memory array: parameter ADDR_W, synchronous write, registered read.
- The top level holds:
  - the FSM;
  - the byte packer;
  - wptr and len;
  - the NOP output mux, implemented as a registered select between RAM data and NOP.

## Test plan
- Reset then idle 10 cycles -> rdata = 0x00000013, core_rst_n_o = 0, load_ready_o = 0 throughout.
- load_len = 2, bytes 13 05 10 00 93 05 20 00 sent back-to-back -> load_done_o pulses one cycle after the 8th byte, with core_rst_n_o = 1 in that same cycle. Then addr 0x000 returns 0x00100513 in the next cycle and addr 0x004 returns 0x00200593.
- Same load with load_valid_i toggled 1,0,1,0 -> identical memory contents. Bytes are accepted only on valid cycles, and the done timing is counted from the last accepted byte.
- load_len = 0 from HOLD -> RUN one cycle later, load_done_o pulses, and no memory write occurs.
- In RUN, load_start_i with len = 1 -> core_rst_n_o = 0 on the next cycle, rdata = NOP while in LOAD, and the new word is visible at addr 0 after done.
- rst_n asserted after 5 bytes of a 2-word load -> all outputs back at reset values. Word 0 is retained and is readable after a subsequent len = 0 load.
- Additional check: load_len = 0x7FF with depth 1024 -> clamped to 1024 words, and done follows the 4096th byte.
